// File: rtl/execute_pkg.sv
// Shared encodings for the execute stage and its multiply/divide unit.
//   md_op_t  : 3-bit multiply/divide opcode carried with each instruction
//   MD_*     : md_op encodings (MD_MT writes HI or LO, selected by imm[0])
//   ST_*     : multiply/divide FSM state encodings
//   DIV0_LO  : quotient returned for a divide by zero (all ones, sliced to width)
//   ALU_*    : alu function codes (MIPS funct values, LUI uses a spare code)
package execute_pkg;

  typedef logic [2:0] md_op_t;

  localparam md_op_t MD_NONE  = 3'd0;
  localparam md_op_t MD_MULT  = 3'd1;
  localparam md_op_t MD_MULTU = 3'd2;
  localparam md_op_t MD_DIV   = 3'd3;
  localparam md_op_t MD_DIVU  = 3'd4;
  localparam md_op_t MD_MFHI  = 3'd5;
  localparam md_op_t MD_MFLO  = 3'd6;
  localparam md_op_t MD_MT    = 3'd7;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;

  localparam logic [63:0] DIV0_LO = '1;

  localparam logic [5:0] ALU_SLL  = 6'h00;
  localparam logic [5:0] ALU_SRL  = 6'h02;
  localparam logic [5:0] ALU_SRA  = 6'h03;
  localparam logic [5:0] ALU_LUI  = 6'h0F;
  localparam logic [5:0] ALU_ADD  = 6'h20;
  localparam logic [5:0] ALU_ADDU = 6'h21;
  localparam logic [5:0] ALU_SUB  = 6'h22;
  localparam logic [5:0] ALU_SUBU = 6'h23;
  localparam logic [5:0] ALU_AND  = 6'h24;
  localparam logic [5:0] ALU_OR   = 6'h25;
  localparam logic [5:0] ALU_XOR  = 6'h26;
  localparam logic [5:0] ALU_NOR  = 6'h27;
  localparam logic [5:0] ALU_SLT  = 6'h2A;
  localparam logic [5:0] ALU_SLTU = 6'h2B;

  // MULT, MULTU, DIV, DIVU start a sequential operation.
  function automatic logic md_is_arith(input md_op_t op);
    return (op >= MD_MULT) && (op <= MD_DIVU);
  endfunction

endpackage

// File: rtl/execute_md_if.sv
// ID/EX -> EX -> EX/MEM bundle for the execute stage.
//   master : decode side, drives the i_* instruction fields
//   slave  : execute stage, drives the o_* results and stall/busy
interface execute_md_if #(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 26,
  parameter int CTRL_W = 6
);
  logic              i_valid;
  logic [IMM_W-1:0]  i_imm;
  logic [DATA_W-1:0] i_op1;
  logic [DATA_W-1:0] i_op2;
  logic              i_ALUSrc_op1;
  logic              i_ALUSrc_op2;
  logic [CTRL_W-1:0] i_ALUCtrl;
  logic              i_extOp;
  logic [2:0]        i_md_op;
  logic [DATA_W-1:0] o_op2;
  logic [DATA_W-1:0] o_ALUres;
  logic              o_arithmetic_overflow;
  logic              o_stall;
  logic              o_md_busy;

  modport master (
    output i_valid, i_imm, i_op1, i_op2, i_ALUSrc_op1, i_ALUSrc_op2,
           i_ALUCtrl, i_extOp, i_md_op,
    input  o_op2, o_ALUres, o_arithmetic_overflow, o_stall, o_md_busy
  );

  modport slave (
    input  i_valid, i_imm, i_op1, i_op2, i_ALUSrc_op1, i_ALUSrc_op2,
           i_ALUCtrl, i_extOp, i_md_op,
    output o_op2, o_ALUres, o_arithmetic_overflow, o_stall, o_md_busy
  );
endinterface

// File: rtl/alu.sv
// Combinational alu.
//   op1, op2 : operands (op1 carries the shift amount for shifts)
//   ctrl     : function code (ALU_* in execute_pkg)
//   res      : result
//   ovf      : signed overflow, ADD/SUB only
module alu
  import execute_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 6
) (
  input  logic [DATA_W-1:0] op1,
  input  logic [DATA_W-1:0] op2,
  input  logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] res,
  output logic              ovf
);
  localparam int SH_W = $clog2(DATA_W);

  logic [SH_W-1:0]   sh;
  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] diff;

  assign sh = op1[SH_W-1:0];

  always_comb begin
    res  = '0;
    ovf  = 1'b0;
    sum  = op1 + op2;
    diff = op1 - op2;
    case (ctrl)
      ALU_ADD: begin
        res = sum;
        ovf = (op1[DATA_W-1] == op2[DATA_W-1]) && (sum[DATA_W-1] != op1[DATA_W-1]);
      end
      ALU_ADDU: res = sum;
      ALU_SUB: begin
        res = diff;
        ovf = (op1[DATA_W-1] != op2[DATA_W-1]) && (diff[DATA_W-1] != op1[DATA_W-1]);
      end
      ALU_SUBU: res = diff;
      ALU_AND:  res = op1 & op2;
      ALU_OR:   res = op1 | op2;
      ALU_XOR:  res = op1 ^ op2;
      ALU_NOR:  res = ~(op1 | op2);
      ALU_SLT:  res = {{(DATA_W-1){1'b0}}, ($signed(op1) < $signed(op2))};
      ALU_SLTU: res = {{(DATA_W-1){1'b0}}, (op1 < op2)};
      ALU_SLL:  res = op2 << sh;
      ALU_SRL:  res = op2 >> sh;
      ALU_SRA:  res = $unsigned($signed(op2) >>> sh);
      ALU_LUI:  res = {op2[DATA_W-17:0], 16'h0000};
      default:  res = '0;
    endcase
  end
endmodule

// File: rtl/execute_md_muldiv_seq.sv
// Sequential multiply/divide unit owning the HI/LO registers.
//   start        : accept a MULT/MULTU/DIV/DIVU this cycle (only honoured in IDLE)
//   op           : md opcode of the started operation
//   a, b         : rs/rt operands (multiplicand/multiplier, dividend/divisor)
//   busy         : operation in flight (BUSY or FIX)
//   hi, lo       : architectural HI/LO
//   mt_we/mt_sel : MTHI/MTLO write strobe, mt_sel 0 HI / 1 LO
//   mt_data      : value written by MTHI/MTLO
// Operations run on magnitudes for DATA_W cycles (radix-2 shift-add multiply,
// restoring divide), then one FIX cycle applies signs and writes HI/LO.
module muldiv_seq
  import execute_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  md_op_t            op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  input  logic              mt_we,
  input  logic              mt_sel,
  input  logic [DATA_W-1:0] mt_data
);
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int PW    = 2 * DATA_W;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;

  // Operation context captured at issue.
  logic is_div_p0;
  logic neg_q_p0;
  logic neg_r_p0;
  logic div0_p0;

  // Working registers: acc is the product high half / partial remainder,
  // shq is the multiplier (product low half) / dividend->quotient shifter,
  // opb is the multiplicand / divisor magnitude.
  logic [DATA_W-1:0] acc_p0;
  logic [DATA_W-1:0] shq_p0;
  logic [DATA_W-1:0] opb_p0;

  logic            is_signed;
  logic [DATA_W:0] mul_sum;
  logic [DATA_W:0] div_shift;
  logic [DATA_W:0] div_sub;
  logic            div_ok;

  function automatic logic [DATA_W-1:0] mag(input logic signed [DATA_W-1:0] v,
                                            input logic sgn);
    return (sgn && (v < 0)) ? (~v + DATA_W'(1)) : v;
  endfunction

  function automatic logic [DATA_W-1:0] fix_sign_w(input logic [DATA_W-1:0] v,
                                                   input logic neg);
    return neg ? (~v + DATA_W'(1)) : v;
  endfunction

  function automatic logic [PW-1:0] fix_sign_p(input logic [PW-1:0] v,
                                               input logic neg);
    return neg ? (~v + PW'(1)) : v;
  endfunction

  assign busy      = (state != ST_IDLE);
  assign is_signed = (op == MD_MULT) || (op == MD_DIV);

  always_comb begin
    mul_sum   = {1'b0, acc_p0} + (shq_p0[0] ? {1'b0, opb_p0} : '0);
    div_shift = {acc_p0, shq_p0[DATA_W-1]};
    div_ok    = (div_shift >= {1'b0, opb_p0});
    div_sub   = div_ok ? (div_shift - {1'b0, opb_p0}) : div_shift;
  end

  // Issue -> iterate: load magnitudes in IDLE, one bit per BUSY cycle.
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && start) begin
      acc_p0    <= '0;
      shq_p0    <= mag(a, is_signed);
      opb_p0    <= mag(b, is_signed);
      is_div_p0 <= (op == MD_DIV) || (op == MD_DIVU);
      neg_q_p0  <= is_signed && (a[DATA_W-1] ^ b[DATA_W-1]);
      neg_r_p0  <= is_signed && a[DATA_W-1];
      div0_p0   <= (b == '0);
    end else if (state == ST_BUSY) begin
      if (is_div_p0) begin
        acc_p0 <= div_sub[DATA_W-1:0];
        shq_p0 <= {shq_p0[DATA_W-2:0], div_ok};
      end else begin
        acc_p0 <= mul_sum[DATA_W:1];
        shq_p0 <= {mul_sum[0], shq_p0[DATA_W-1:1]};
      end
    end
  end

  // Control and architectural HI/LO; FIX applies signs and commits.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_BUSY;
            cnt   <= CNT_W'(DATA_W);
          end else if (mt_we) begin
            if (mt_sel) lo <= mt_data;
            else        hi <= mt_data;
          end
        end
        ST_BUSY: begin
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) state <= ST_FIX;
        end
        ST_FIX: begin
          if (is_div_p0) begin
            // Divide by zero leaves the raw dividend in the remainder path,
            // so the remainder sign rule restores the signed dividend in HI.
            lo <= div0_p0 ? DIV0_LO[DATA_W-1:0] : fix_sign_w(shq_p0, neg_q_p0);
            hi <= fix_sign_w(acc_p0, neg_r_p0);
          end else begin
            {hi, lo} <= fix_sign_p({acc_p0, shq_p0}, neg_q_p0);
          end
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: rtl/mux2in1.sv
// Two-input W-bit multiplexer.
//   sel : 0 selects in0, 1 selects in1
module mux2in1 #(
  parameter int W = 32
) (
  input  logic         sel,
  input  logic [W-1:0] in0,
  input  logic [W-1:0] in1,
  output logic [W-1:0] out
);
  assign out = sel ? in1 : in0;
endmodule

// File: rtl/signExtend.sv
// Immediate extender: 16-bit field to DATA_W, sign- or zero-extended.
//   imm    : immediate bits [15:0]
//   ext_op : 1 sign-extend, 0 zero-extend
//   ext    : extended value
module signExtend #(
  parameter int DATA_W = 32
) (
  input  logic [15:0]       imm,
  input  logic              ext_op,
  output logic [DATA_W-1:0] ext
);
  assign ext = ext_op ? {{(DATA_W-16){imm[15]}}, imm}
                      : {{(DATA_W-16){1'b0}}, imm};
endmodule

// File: rtl/execute_md.sv
// MIPS execute stage with a sequential multiply/divide unit.
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   bus (slave)    : i_valid, i_imm, i_op1, i_op2, i_ALUSrc_op1/op2, i_ALUCtrl,
//                    i_extOp, i_md_op in; o_op2 (store data), o_ALUres,
//                    o_arithmetic_overflow, o_stall, o_md_busy out
// The alu path is combinational. An instruction that touches the multiply/
// divide unit (start, MFHI/MFLO, MTHI/MTLO) stalls while an operation is in
// flight; ordinary alu instructions keep flowing.
module execute_md
  import execute_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int IMM_W     = 26,
  parameter int SHAMT_LSB = 6,
  parameter int CTRL_W    = 6
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  execute_md_if.slave bus
);
  logic [DATA_W-1:0] imm_ext;
  logic [DATA_W-1:0] shamt_ext;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_res;
  logic              alu_ovf;
  logic              md_busy;
  logic [DATA_W-1:0] md_hi;
  logic [DATA_W-1:0] md_lo;
  logic              md_start;
  logic              md_mt_we;
  logic              md_any;
  logic              unused_imm;

  assign shamt_ext  = DATA_W'(bus.i_imm[SHAMT_LSB+4:SHAMT_LSB]);
  assign unused_imm = ^bus.i_imm[IMM_W-1:16];

  signExtend #(.DATA_W(DATA_W)) u_ext (
    .imm    (bus.i_imm[15:0]),
    .ext_op (bus.i_extOp),
    .ext    (imm_ext)
  );

  mux2in1 #(.W(DATA_W)) u_mux_op1 (
    .sel (bus.i_ALUSrc_op1),
    .in0 (bus.i_op1),
    .in1 (shamt_ext),
    .out (alu_a)
  );

  mux2in1 #(.W(DATA_W)) u_mux_op2 (
    .sel (bus.i_ALUSrc_op2),
    .in0 (bus.i_op2),
    .in1 (imm_ext),
    .out (alu_b)
  );

  alu #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_alu (
    .op1  (alu_a),
    .op2  (alu_b),
    .ctrl (bus.i_ALUCtrl),
    .res  (alu_res),
    .ovf  (alu_ovf)
  );

  // Anything that reads or writes HI/LO, or starts an operation, must wait
  // for IDLE; it is accepted in the first IDLE cycle.
  assign md_any   = (bus.i_md_op != MD_NONE);
  assign md_start = bus.i_valid && !md_busy && md_is_arith(bus.i_md_op);
  assign md_mt_we = bus.i_valid && !md_busy && (bus.i_md_op == MD_MT);

  muldiv_seq #(.DATA_W(DATA_W)) u_md (
    .clk     (i_clk),
    .rst_n   (i_rst_n),
    .start   (md_start),
    .op      (bus.i_md_op),
    .a       (bus.i_op1),
    .b       (bus.i_op2),
    .busy    (md_busy),
    .hi      (md_hi),
    .lo      (md_lo),
    .mt_we   (md_mt_we),
    .mt_sel  (bus.i_imm[0]),
    .mt_data (bus.i_op1)
  );

  always_comb begin
    case (bus.i_md_op)
      MD_MFHI: bus.o_ALUres = md_hi;
      MD_MFLO: bus.o_ALUres = md_lo;
      default: bus.o_ALUres = alu_res;
    endcase
  end

  assign bus.o_op2                 = bus.i_op2;
  assign bus.o_arithmetic_overflow = alu_ovf && !md_any;
  assign bus.o_stall               = bus.i_valid && md_busy && md_any;
  assign bus.o_md_busy             = md_busy;
endmodule

// File: tb/tb_execute_md.sv
module tb_execute_md;

  localparam logic [5:0] ALU_CODES [14] = '{6'h00, 6'h02, 6'h03, 6'h0F, 6'h20, 6'h21, 6'h22,
                                            6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};
  localparam longint IMAX = 64'sh7FFF_FFFF;
  localparam longint IMIN = -64'sh8000_0000;
  localparam int     LAT  = 33;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  execute_md_if ex_if ();

  execute_md dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (ex_if)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: architectural HI/LO, the pending result and the number
  // of cycles until it lands.
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  int          m_cnt = 0;

  logic [31:0] obs_res;
  logic        obs_stall, obs_ovf;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void alu_ref(input logic [5:0] c, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic v);
    longint s;
    r = '0;
    v = 1'b0;
    case (c)
      6'h20: begin s = longint'($signed(a)) + longint'($signed(b)); r = a + b; v = (s > IMAX) || (s < IMIN); end
      6'h21: r = a + b;
      6'h22: begin s = longint'($signed(a)) - longint'($signed(b)); r = a - b; v = (s > IMAX) || (s < IMIN); end
      6'h23: r = a - b;
      6'h24: r = a & b;
      6'h25: r = a | b;
      6'h26: r = a ^ b;
      6'h27: r = ~(a | b);
      6'h2A: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      6'h2B: r = (a < b) ? 32'd1 : 32'd0;
      6'h00: r = b << a[4:0];
      6'h02: r = b >> a[4:0];
      6'h03: r = $signed(b) >>> a[4:0];
      6'h0F: r = b << 16;
      default: r = '0;
    endcase
  endfunction

  function automatic void md_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] h, output logic [31:0] l);
    longint      p;
    logic [63:0] pu;
    int          sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    h = '0;
    l = '0;
    case (op)
      3'd1: begin p = longint'(sa) * longint'(sb); h = p[63:32]; l = p[31:0]; end
      3'd2: begin pu = {32'b0, a} * {32'b0, b}; h = pu[63:32]; l = pu[31:0]; end
      3'd3: begin
        if (b == 0) begin l = '1; h = a; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin l = a; h = '0; end
        else begin l = sa / sb; h = sa % sb; end
      end
      3'd4: begin
        if (b == 0) begin l = '1; h = a; end
        else begin l = a / b; h = a % b; end
      end
      default: ;
    endcase
  endfunction

  task automatic drive(input logic v, input logic [2:0] md, input logic [5:0] c,
                       input logic [31:0] a, input logic [31:0] b, input logic [25:0] imm,
                       input logic s1, input logic s2, input logic e);
    ex_if.i_valid      = v;
    ex_if.i_md_op      = md;
    ex_if.i_ALUCtrl    = c;
    ex_if.i_op1        = a;
    ex_if.i_op2        = b;
    ex_if.i_imm        = imm;
    ex_if.i_ALUSrc_op1 = s1;
    ex_if.i_ALUSrc_op2 = s2;
    ex_if.i_extOp      = e;
  endtask

  // One clock: check outputs on the falling edge, advance the model on the rising edge.
  task automatic cycle();
    logic [31:0] opa, opb, r_exp;
    logic        v_exp, exp_stall;
    logic [2:0]  md;
    logic [25:0] imm;
    @(negedge clk);
    md  = ex_if.i_md_op;
    imm = ex_if.i_imm;
    opa = ex_if.i_ALUSrc_op1 ? {27'b0, imm[10:6]} : ex_if.i_op1;
    opb = ex_if.i_ALUSrc_op2 ? (ex_if.i_extOp ? {{16{imm[15]}}, imm[15:0]} : {16'b0, imm[15:0]})
                             : ex_if.i_op2;
    alu_ref(ex_if.i_ALUCtrl, opa, opb, r_exp, v_exp);
    exp_stall = ex_if.i_valid && (m_cnt > 0) && (md != 3'd0);
    check("stall", 32'(ex_if.o_stall), 32'(exp_stall));
    check("md_busy", 32'(ex_if.o_md_busy), 32'(m_cnt > 0));
    check("op2_pass", ex_if.o_op2, ex_if.i_op2);
    if (md == 3'd5)      check("mfhi_read", ex_if.o_ALUres, m_hi);
    else if (md == 3'd6) check("mflo_read", ex_if.o_ALUres, m_lo);
    else                 check("alu_res", ex_if.o_ALUres, r_exp);
    check("overflow", 32'(ex_if.o_arithmetic_overflow), 32'((md == 3'd0) ? v_exp : 1'b0));
    obs_res   = ex_if.o_ALUres;
    obs_stall = ex_if.o_stall;
    obs_ovf   = ex_if.o_arithmetic_overflow;
    @(posedge clk);
    if (!rst_n) begin
      m_cnt = 0; m_hi = '0; m_lo = '0;
    end else if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 0) begin m_hi = p_hi; m_lo = p_lo; end
    end else if (ex_if.i_valid) begin
      if (md >= 3'd1 && md <= 3'd4) begin
        md_ref(md, ex_if.i_op1, ex_if.i_op2, p_hi, p_lo);
        m_cnt = LAT;
      end else if (md == 3'd7) begin
        if (imm[0]) m_lo = ex_if.i_op1;
        else        m_hi = ex_if.i_op1;
      end
    end
    #1;
  endtask

  // Present an instruction until it is no longer stalled.
  task automatic present(input logic [2:0] md, input logic [31:0] a, input logic [31:0] b,
                         input logic [25:0] imm, output int stalls);
    stalls = 0;
    drive(1'b1, md, 6'h21, a, b, imm, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 100; i++) begin
      cycle();
      if (!obs_stall) break;
      stalls++;
    end
    if (stalls >= 100) check("stall_timeout", 32'd1, 32'd0);
    drive(1'b0, 3'd0, 6'h21, 32'd0, 32'd0, 26'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    drive(1'b0, 3'd0, 6'h21, 32'd0, 32'd0, 26'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    logic [31:0] r, a, b;
    logic [2:0]  md;
    int          sel;

    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(1);

    present(3'd5, 32'd0, 32'd0, 26'd0, n);
    check("reset_hi", obs_res, 32'd0);
    present(3'd6, 32'd0, 32'd0, 26'd0, n);
    check("reset_lo", obs_res, 32'd0);

    drive(1'b1, 3'd0, 6'h20, 32'd7, 32'd5, 26'd0, 1'b0, 1'b0, 1'b0);
    cycle();
    check("add_7_5", obs_res, 32'd12);
    check("add_no_stall", 32'(obs_stall), 32'd0);
    drive(1'b1, 3'd0, 6'h20, 32'h7FFF_FFFF, 32'd1, 26'd0, 1'b0, 1'b0, 1'b0);
    cycle();
    check("add_ovf", 32'(obs_ovf), 32'd1);

    // MULT -3 x 7 followed immediately by MFLO / MFHI.
    present(3'd1, 32'hFFFF_FFFD, 32'd7, 26'd0, n);
    check("mult_issue_stall", n, 0);
    present(3'd6, 32'd0, 32'd0, 26'd0, n);
    check("mflo_stall_cycles", n, 33);
    check("mult_lo", obs_res, 32'hFFFF_FFEB);
    present(3'd5, 32'd0, 32'd0, 26'd0, n);
    check("mult_hi", obs_res, 32'hFFFF_FFFF);
    check("mfhi_no_stall", n, 0);

    // MULTU, then MFHI exactly DATA_W+2 cycles after issue (no stall).
    present(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 26'd0, n);
    idle(33);
    present(3'd5, 32'd0, 32'd0, 26'd0, n);
    check("multu_hi", obs_res, 32'hFFFF_FFFE);
    check("mfhi_at_lat_stall", n, 0);
    present(3'd6, 32'd0, 32'd0, 26'd0, n);
    check("multu_lo", obs_res, 32'h0000_0001);

    // One cycle too early still stalls once.
    present(3'd2, 32'd3, 32'd5, 26'd0, n);
    idle(32);
    present(3'd6, 32'd0, 32'd0, 26'd0, n);
    check("mflo_early_stall", n, 1);
    check("multu_small_lo", obs_res, 32'd15);

    present(3'd3, 32'hFFFF_FFF9, 32'd2, 26'd0, n);
    present(3'd6, 32'd0, 32'd0, 26'd0, n);
    check("div_lo", obs_res, 32'hFFFF_FFFD);
    present(3'd5, 32'd0, 32'd0, 26'd0, n);
    check("div_hi", obs_res, 32'hFFFF_FFFF);

    present(3'd4, 32'd100, 32'd0, 26'd0, n);
    present(3'd6, 32'd0, 32'd0, 26'd0, n);
    check("divu0_lo", obs_res, 32'hFFFF_FFFF);
    present(3'd5, 32'd0, 32'd0, 26'd0, n);
    check("divu0_hi", obs_res, 32'd100);

    present(3'd3, 32'hFFFF_FFFB, 32'd0, 26'd0, n);
    present(3'd5, 32'd0, 32'd0, 26'd0, n);
    check("div0_hi", obs_res, 32'hFFFF_FFFB);
    present(3'd6, 32'd0, 32'd0, 26'd0, n);
    check("div0_lo", obs_res, 32'hFFFF_FFFF);

    present(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 26'd0, n);
    present(3'd6, 32'd0, 32'd0, 26'd0, n);
    check("divmin_lo", obs_res, 32'h8000_0000);
    present(3'd5, 32'd0, 32'd0, 26'd0, n);
    check("divmin_hi", obs_res, 32'd0);

    // Independent alu work during BUSY, then a second MULT that must wait.
    present(3'd1, 32'd6, 32'd9, 26'd0, n);
    for (int i = 0; i < 5; i++) begin
      a = $urandom();
      b = $urandom();
      drive(1'b1, 3'd0, 6'h21, a, b, 26'd0, 1'b0, 1'b0, 1'b0);
      cycle();
      check("busy_add", obs_res, a + b);
    end
    present(3'd1, 32'd2, 32'd3, 26'd0, n);
    check("mult2_stalls", n, 28);
    present(3'd6, 32'd0, 32'd0, 26'd0, n);
    check("mult2_lo", obs_res, 32'd6);

    // MTHI / MTLO.
    present(3'd7, 32'h1234_5678, 32'd0, 26'd0, n);
    present(3'd7, 32'h9ABC_DEF0, 32'd0, 26'd1, n);
    present(3'd5, 32'd0, 32'd0, 26'd0, n);
    check("mthi", obs_res, 32'h1234_5678);
    present(3'd6, 32'd0, 32'd0, 26'd0, n);
    check("mtlo", obs_res, 32'h9ABC_DEF0);

    // Reset in the BUSY cycle where the counter reads 10.
    present(3'd1, 32'd5, 32'd5, 26'd0, n);
    idle(22);
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    present(3'd6, 32'd0, 32'd0, 26'd0, n);
    check("rst_abort_lo", obs_res, 32'd0);
    check("rst_abort_stall", n, 0);
    present(3'd5, 32'd0, 32'd0, 26'd0, n);
    check("rst_abort_hi", obs_res, 32'd0);

    // Randomized mix checked against the reference model every cycle.
    for (int i = 0; i < 400; i++) begin
      r   = $urandom();
      sel = $urandom_range(0, 19);
      if (sel < 3)       md = 3'($urandom_range(1, 4));
      else if (sel == 3) md = 3'd5;
      else if (sel == 4) md = 3'd6;
      else if (sel == 5) md = 3'd7;
      else               md = 3'd0;
      a = $urandom();
      b = $urandom();
      if (r[4:2] == 3'd0) b = 32'd0;
      if (r[7:5] == 3'd0) a = 32'h8000_0000;
      if (r[10:8] == 3'd0) b = 32'hFFFF_FFFF;
      drive(r[0] | r[1], md, ALU_CODES[$urandom_range(0, 13)], a, b, r[31:6],
            r[11], r[12], r[13]);
      cycle();
    end
    idle(40);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
